// File: rtl/lif_neuron_multi.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_multi
// Brief    : Multi-synapse leaky integrate-and-fire neuron with a writable
//            weight file, linear/shift leak and a refractory period.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_multi #(
  parameter int NUM_INPUTS      = 4,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int POTENTIAL_WIDTH = 12,
  parameter int REFRAC_WIDTH    = 4,
  parameter int COUNT_WIDTH     = 16,
  parameter int DEFAULT_WEIGHT  = 10,
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_INPUTS-1:0]      in_spikes,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]    cfg_wdata,
  input  logic [POTENTIAL_WIDTH-1:0] threshold,
  input  logic [POTENTIAL_WIDTH-1:0] leak,
  input  logic                       leak_mode,
  input  logic [REFRAC_WIDTH-1:0]    refrac_period,
  output logic                       spike_out,
  output logic [POTENTIAL_WIDTH-1:0] membrane,
  output logic                       refractory,
  output logic [COUNT_WIDTH-1:0]     spike_count
);

  localparam int SW  = POTENTIAL_WIDTH + AW + 2;
  localparam int SHW = (POTENTIAL_WIDTH > 1) ? $clog2(POTENTIAL_WIDTH) : 1;

  localparam logic [0:0] S_ACTIVE     = 1'b0;
  localparam logic [0:0] S_REFRACTORY = 1'b1;

  localparam logic signed [WEIGHT_WIDTH-1:0] c_DEFAULT_W = WEIGHT_WIDTH'(DEFAULT_WEIGHT);
  localparam logic signed [SW-1:0] c_MEM_MAX =
    {{(SW-POTENTIAL_WIDTH+1){1'b0}}, {(POTENTIAL_WIDTH-1){1'b1}}};

  logic signed [WEIGHT_WIDTH-1:0]    r_weight [NUM_INPUTS];
  logic signed [POTENTIAL_WIDTH-1:0] r_membrane;
  logic                              r_spike;
  logic [COUNT_WIDTH-1:0]            r_count;
  logic [REFRAC_WIDTH-1:0]           r_refrac_cnt;
  logic [0:0]                        r_state;
  logic [0:0]                        w_state_nxt;

  logic signed [SW-1:0]              w_sum;
  logic signed [SW-1:0]              w_mem_ext;
  logic signed [SW-1:0]              w_leak_amt;
  logic signed [SW-1:0]              w_next;
  logic signed [POTENTIAL_WIDTH-1:0] w_clamped;
  logic [SHW-1:0]                    w_shift;
  logic                              w_fire;
  logic                              w_do_integrate;
  logic                              w_do_fire;
  logic                              w_do_countdown;

  // Out-of-range addresses match no entry, so those writes fall away.
  generate
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_weight
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_weight[g] <= c_DEFAULT_W;
        end else if (cfg_we && ({1'b0, cfg_addr} == (AW+1)'(g))) begin
          r_weight[g] <= cfg_wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_spikes[i]) begin
        w_sum = w_sum + SW'(r_weight[i]);
      end
    end
  end

  // Wide signed datapath: the sum and leak can never wrap before clamping.
  always_comb begin
    w_shift    = leak[SHW-1:0];
    w_mem_ext  = SW'(r_membrane);
    w_leak_amt = leak_mode ? (w_mem_ext >>> w_shift) : SW'($signed(leak));
    w_next     = w_mem_ext + w_sum - w_leak_amt;
    if (w_next < 0) begin
      w_clamped = '0;
    end else if (w_next > c_MEM_MAX) begin
      w_clamped = c_MEM_MAX[POTENTIAL_WIDTH-1:0];
    end else begin
      w_clamped = w_next[POTENTIAL_WIDTH-1:0];
    end
    w_fire = (w_clamped >= $signed(threshold));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACTIVE: begin
        if (enable && w_fire && (refrac_period != '0)) begin
          w_state_nxt = S_REFRACTORY;
        end
      end
      S_REFRACTORY: begin
        if (enable && (r_refrac_cnt == REFRAC_WIDTH'(1))) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      default: w_state_nxt = S_ACTIVE;
    endcase
  end

  always_comb begin
    w_do_integrate = 1'b0;
    w_do_countdown = 1'b0;
    case (r_state)
      S_ACTIVE:     w_do_integrate = enable;
      S_REFRACTORY: w_do_countdown = enable;
      default: begin
        w_do_integrate = 1'b0;
        w_do_countdown = 1'b0;
      end
    endcase
    w_do_fire = w_do_integrate && w_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_membrane   <= '0;
      r_spike      <= 1'b0;
      r_count      <= '0;
      r_refrac_cnt <= '0;
    end else begin
      r_spike <= w_do_fire;
      if (w_do_fire) begin
        r_membrane <= '0;
        if (r_count != '1) begin
          r_count <= r_count + COUNT_WIDTH'(1);
        end
        if (refrac_period != '0) begin
          r_refrac_cnt <= refrac_period;
        end
      end else if (w_do_integrate) begin
        r_membrane <= w_clamped;
      end else if (w_do_countdown) begin
        r_membrane   <= '0;
        r_refrac_cnt <= r_refrac_cnt - REFRAC_WIDTH'(1);
      end
    end
  end

  assign spike_out   = r_spike;
  assign membrane    = r_membrane;
  assign refractory  = (r_state == S_REFRACTORY);
  assign spike_count = r_count;

endmodule
`default_nettype wire
